// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache that answers load misses
// and committed stores, refilling from and writing through to main memory.
module dcache_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4,
    WACK   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             unused_addr_bits;

  assign req_idx = req_addr[IDX_W+1:2];
  assign req_tag = req_addr[ADDR_W-1:IDX_W+2];
  assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0], req_addr[1:0]};

  assign mem_req   = (state == FILL) || (state == WRITE);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = req_wdata;
  assign rd_ready  = (state == RESP);
  assign wr_ack    = (state == WACK);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        // Stores are older committed work, so they go ahead of a pending load.
        if (wr_req) begin
          state_nxt = WRITE;
        end else if (rd_req) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP:  state_nxt = hit ? RESP : FILL;
      FILL:    if (mem_ack) state_nxt = RESP;
      WRITE:   if (mem_ack) state_nxt = WACK;
      RESP:    state_nxt = IDLE;
      WACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
      rd_data   <= '0;
      valid     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            req_addr  <= {wr_addr[ADDR_W-1:2], 2'b00};
            req_wdata <= wr_data;
          end else if (rd_req) begin
            req_addr  <= {rd_addr[ADDR_W-1:2], 2'b00};
          end
        end
        LOOKUP: begin
          if (hit) rd_data <= data_mem[req_idx];
        end
        FILL: begin
          if (mem_ack) begin
            valid[req_idx] <= 1'b1;
            rd_data        <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset: the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= mem_rdata;
    end else if (state == WRITE && mem_ack && hit) begin
      data_mem[req_idx] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a behavioural cache/memory model.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  dcache_responder #(.ADDR_W(32), .DATA_W(32), .LINES(16)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Main memory contents (word-addressed, bytes 0x000-0x3FF) and the reference cache.
  logic [31:0] mm [256];
  logic        rv [16];
  logic [31:0] rt [16];
  logic [31:0] rdat [16];

  int n_chk = 0;
  int n_pass = 0;

  // Per-transaction observations gathered by run_txn.
  int          n_mem, rd_k, wr_k, rd_ack_k, wr_ack_k, unstable, bad_drop, spurious;
  logic        tmo;
  logic [31:0] rd_d;
  logic        lg_we    [4];
  logic [31:0] lg_addr  [4];
  logic [31:0] lg_wdata [4];

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          dly;
    logic        exp_hit;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> 6;
  endfunction

  // Drives the requested load and/or store, acts as main memory, records what happened.
  task automatic run_txn(input logic do_rd, input logic [31:0] ra, input logic do_wr,
                         input logic [31:0] wa, input logic [31:0] wd, input int dly);
    int          k, cnt;
    logic        ack_pending, need_rd, need_wr, hold_we;
    logic [31:0] hold_addr, hold_wd;
    n_mem = 0; rd_k = -1; wr_k = -1; rd_ack_k = -1; wr_ack_k = -1; rd_d = '0;
    unstable = 0; bad_drop = 0; spurious = 0; tmo = 1'b0;
    cnt = 0; ack_pending = 1'b0; need_rd = do_rd; need_wr = do_wr;
    hold_we = 1'b0; hold_addr = '0; hold_wd = '0;
    @(negedge clk);
    rd_req = do_rd; rd_addr = ra; wr_req = do_wr; wr_addr = wa; wr_data = wd;
    k = 0;
    while ((need_rd || need_wr) && !tmo) begin
      @(negedge clk);
      k++;
      if (ack_pending) begin
        mem_ack = 1'b0;
        ack_pending = 1'b0;
        if (mem_req) bad_drop++;
      end else if (mem_req) begin
        if (cnt == 0) begin
          hold_we = mem_we; hold_addr = mem_addr; hold_wd = mem_wdata;
          if (n_mem < 4) begin
            lg_we[n_mem] = mem_we; lg_addr[n_mem] = mem_addr; lg_wdata[n_mem] = mem_wdata;
          end
          n_mem++;
        end else if (mem_we != hold_we || mem_addr != hold_addr || mem_wdata != hold_wd) begin
          unstable++;
        end
        cnt++;
        if (cnt >= dly) begin
          mem_ack = 1'b1;
          ack_pending = 1'b1;
          cnt = 0;
          if (mem_we) begin
            mm[mem_addr[9:2]] = mem_wdata;
            wr_ack_k = k;
          end else begin
            mem_rdata = mm[mem_addr[9:2]];
            rd_ack_k = k;
          end
        end
      end
      if (rd_ready) begin
        if (!need_rd) spurious++;
        else begin rd_k = k; rd_d = rd_data; rd_req = 1'b0; need_rd = 1'b0; end
      end
      if (wr_ack) begin
        if (!need_wr) spurious++;
        else begin wr_k = k; wr_req = 1'b0; need_wr = 1'b0; end
      end
      if (k > 200) tmo = 1'b1;
    end
    mem_ack = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic check_read(input string nm, input logic [31:0] a, input logic exp_hit,
                            input logic [31:0] exp_d, input int dly);
    logic [31:0] wa;
    int          i;
    wa = {a[31:2], 2'b00};
    i  = idx_of(a);
    run_txn(1'b1, a, 1'b0, '0, '0, dly);
    chk({nm, "_timeout"}, 32'(tmo), 32'd0);
    chk({nm, "_data"}, rd_d, exp_d);
    chk({nm, "_memops"}, n_mem, exp_hit ? 0 : 1);
    if (exp_hit) begin
      chk({nm, "_hit_latency"}, rd_k, 2);
    end else begin
      chk({nm, "_miss_latency"}, rd_k, rd_ack_k + 1);
      chk({nm, "_mem_addr"}, lg_addr[0], wa);
      chk({nm, "_mem_we"}, 32'(lg_we[0]), 32'd0);
    end
    chk({nm, "_handshake"}, unstable + bad_drop + spurious, 0);
    rv[i] = 1'b1; rt[i] = tag_of(a); rdat[i] = exp_d;
  endtask

  task automatic check_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                             input int dly);
    int i;
    i = idx_of(a);
    run_txn(1'b0, '0, 1'b1, a, d, dly);
    chk({nm, "_timeout"}, 32'(tmo), 32'd0);
    chk({nm, "_memops"}, n_mem, 1);
    chk({nm, "_mem_we"}, 32'(lg_we[0]), 32'd1);
    chk({nm, "_mem_addr"}, lg_addr[0], {a[31:2], 2'b00});
    chk({nm, "_mem_wdata"}, lg_wdata[0], d);
    chk({nm, "_ack_latency"}, wr_k, wr_ack_k + 1);
    chk({nm, "_handshake"}, unstable + bad_drop + spurious, 0);
    if (rv[i] && rt[i] == tag_of(a)) rdat[i] = d;
  endtask

  initial begin
    int          i, waited;
    logic [31:0] a, d;
    logic        h;

    reset = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int j = 0; j < 256; j++) mm[j] = $urandom;
    mm[32'h40 >> 2] = 32'hDEAD_BEEF;
    for (int j = 0; j < 16; j++) begin rv[j] = 1'b0; rt[j] = '0; rdat[j] = '0; end

    vecs[0] = '{1'b0, 32'h40, 32'hDEAD_BEEF, 3, 1'b0};
    vecs[1] = '{1'b0, 32'h42, 32'hDEAD_BEEF, 1, 1'b1};
    vecs[2] = '{1'b1, 32'h40, 32'h1234_5678, 2, 1'b0};
    vecs[3] = '{1'b0, 32'h40, 32'h1234_5678, 2, 1'b1};
    vecs[4] = '{1'b1, 32'h80, 32'h0000_0005, 2, 1'b0};
    vecs[5] = '{1'b0, 32'h80, 32'h0000_0005, 2, 1'b0};
    vecs[6] = '{1'b0, 32'h40, 32'h1234_5678, 2, 1'b0};

    #1;
    chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].is_wr) check_write($sformatf("vec%0d_wr", v), vecs[v].addr, vecs[v].data, vecs[v].dly);
      else check_read($sformatf("vec%0d_rd", v), vecs[v].addr, vecs[v].exp_hit, vecs[v].data, vecs[v].dly);
    end

    // Load and store arrive together: the store to 0x100 (index 0, other tag) goes first
    // and must not allocate, so the load to 0x40 still hits.
    run_txn(1'b1, 32'h40, 1'b1, 32'h100, 32'hCAFE_0001, 2);
    chk("simul_timeout", 32'(tmo), 32'd0);
    chk("simul_memops", n_mem, 1);
    chk("simul_first_we", 32'(lg_we[0]), 32'd1);
    chk("simul_first_addr", lg_addr[0], 32'h100);
    chk("simul_first_wdata", lg_wdata[0], 32'hCAFE_0001);
    chk("simul_order", 32'(wr_k < rd_k), 32'd1);
    chk("simul_rd_data", rd_d, 32'h1234_5678);

    // Reset while a refill is outstanding.
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h200;
    waited = 0;
    while (!mem_req && waited < 10) begin @(negedge clk); waited++; end
    chk("rstfill_mem_req_seen", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstfill_mem_req_drop", 32'(mem_req), 32'd0);
    chk("rstfill_busy", 32'(busy), 32'd0);
    rd_req = 1'b0;
    h = 1'b0;
    repeat (3) begin @(negedge clk); if (rd_ready || wr_ack) h = 1'b1; end
    reset = 1'b1;
    @(negedge clk);
    if (rd_ready || wr_ack) h = 1'b1;
    chk("rstfill_no_pulse", 32'(h), 32'd0);
    for (int j = 0; j < 16; j++) rv[j] = 1'b0;
    check_read("rstfill_refetch", 32'h200, 1'b0, mm[32'h200 >> 2], 2);
    check_read("rstfill_old_line", 32'h44, 1'b0, mm[32'h44 >> 2], 1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      i = idx_of(a);
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        check_write($sformatf("rnd%0d_wr", n), a, d, int'($urandom_range(1, 4)));
      end else begin
        h = rv[i] && (rt[i] == tag_of(a));
        d = h ? rdat[i] : mm[a[9:2]];
        check_read($sformatf("rnd%0d_rd", n), a, h, d, int'($urandom_range(1, 4)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
